// File: rtl/operand_loader.sv
// Operand entry for the 4-bit comparator: synchronises switches and buttons,
// debounces the buttons and loads A then B on each accepted load press.
module operand_loader_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q, prime_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d, prev_q, armed_q, armed_d, pulse_q;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) deb_d = ~deb_q;
      else                                  cnt_d = cnt_q + 1'b1;
    end
    // A button held through reset must be seen released before it may pulse;
    // prime_q marks when sync_q[1] carries a real post-reset sample.
    armed_d = armed_q | (prime_q[1] & ~deb_q & ~sync_q[1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prime_q <= '0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      prime_q <= {prime_q[0], 1'b1};
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      prev_q  <= deb_q;
      armed_q <= armed_d;
      pulse_q <= armed_q & deb_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

module operand_loader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             valid,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {WAIT_A = 2'b00, WAIT_B = 2'b01, READY = 2'b10} state_e;

  logic [1:0][WIDTH-1:0] sw_sync_q;
  logic [1:0]            btn_raw, btn_pulse;
  logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
  logic                  valid_q, valid_d;
  state_e                state_q, state_d;

  assign btn_raw = {btn_clear, btn_load};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    operand_loader_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_raw[i]),
      .pulse_o(btn_pulse[i])
    );
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    if (btn_pulse[1]) begin
      state_d = WAIT_A;
      a_d     = '0;
      b_d     = '0;
      valid_d = 1'b0;
    end else if (btn_pulse[0]) begin
      case (state_q)
        WAIT_A: begin a_d = sw_sync_q[1]; state_d = WAIT_B; end
        WAIT_B: begin b_d = sw_sync_q[1]; valid_d = 1'b1; state_d = READY; end
        READY:  begin a_d = sw_sync_q[1]; valid_d = 1'b0; state_d = WAIT_B; end
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync_q <= '0;
      state_q   <= WAIT_A;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
    end else begin
      sw_sync_q <= {sw_sync_q[0], sw};
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign valid = valid_q;
  assign state = state_q;
endmodule

// File: tb/tb_operand_loader.sv
// Directed plus randomized bench for operand_loader against a history-based
// reference model of sync, debounce, press detection and operand capture.
module tb_operand_loader;
  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw = '0;
  logic         btn_load = 1'b0;
  logic         btn_clear = 1'b0;
  logic [W-1:0] A, B;
  logic         valid;
  logic [1:0]   state;

  operand_loader #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .btn_load (btn_load),
    .btn_clear(btn_clear),
    .A        (A),
    .B        (B),
    .valid    (valid),
    .state    (state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: raw input samples indexed by edge number since reset release.
  int           n;
  bit           hl [0:65535];
  bit           hc [0:65535];
  logic [W-1:0] hs [0:65535];
  bit           deb_l, deb_c, arm_l, arm_c;
  typedef struct { int at; bit clr; logic [W-1:0] v; } op_t;
  op_t          ops[$];
  logic [W-1:0] mA, mB;
  bit           mV;
  logic [1:0]   mS;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit samp(input bit clr, input int k);
    if (k < 0) return 1'b0;
    return clr ? hc[k] : hl[k];
  endfunction

  task automatic mreset();
    n = 0;
    deb_l = 0; deb_c = 0; arm_l = 0; arm_c = 0;
    ops.delete();
    mA = '0; mB = '0; mV = 0; mS = 2'b00;
  endtask

  task automatic model_step();
    bit c, l, d, a, flip;
    logic [W-1:0] v;
    op_t o;
    for (int b = 0; b < 2; b++) begin
      d = (b == 1) ? deb_c : deb_l;
      a = (b == 1) ? arm_c : arm_l;
      // released once a real post-reset sample shows low while debounced low
      if (n >= 2 && !d && !samp(b[0], n - 2)) a = 1;
      // level accepted once the last D synchronised samples all disagree with it
      flip = 1;
      for (int i = 0; i < D; i++)
        if (samp(b[0], n - 2 - i) == d) flip = 0;
      if (flip) begin
        d = !d;
        if (d && a) begin
          o.at = n + 2; o.clr = b[0]; o.v = hs[n];
          ops.push_back(o);
        end
      end
      if (b == 1) begin deb_c = d; arm_c = a; end
      else        begin deb_l = d; arm_l = a; end
    end
    c = 0; l = 0; v = '0;
    while (ops.size() > 0 && ops[0].at == n) begin
      o = ops.pop_front();
      if (o.clr) c = 1;
      else begin l = 1; v = o.v; end
    end
    if (c) begin
      mA = '0; mB = '0; mV = 0; mS = 2'b00;
    end else if (l) begin
      if (mS == 2'b00)      begin mA = v; mS = 2'b01; end
      else if (mS == 2'b01) begin mB = v; mV = 1; mS = 2'b10; end
      else                  begin mA = v; mV = 0; mS = 2'b01; end
    end
  endtask

  task automatic tick();
    hl[n] = btn_load; hc[n] = btn_clear; hs[n] = sw;
    @(posedge clk);
    model_step();
    n++;
    #1;
    chk("A", A, mA);
    chk("B", B, mB);
    chk("valid", valid, mV);
    chk("state", state, mS);
  endtask

  task automatic rst_pulse(input logic [W-1:0] swv);
    #3;
    sw = swv;
    rst_n = 1'b0;
    #1;
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_valid", valid, 0);
    chk("rst_state", state, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    mreset();
  endtask

  task automatic press(input bit l, input bit c, input int hold, input int rel);
    btn_load = l; btn_clear = c;
    repeat (hold) tick();
    btn_load = 1'b0; btn_clear = 1'b0;
    repeat (rel) tick();
  endtask

  initial begin
    #1;
    chk("por_A", A, 0);
    chk("por_state", state, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    mreset();
    repeat (5) tick();

    // asynchronous reset mid-cycle
    rst_pulse(4'hF);
    repeat (5) tick();

    // pair load with exact latency
    sw = 4'h9; btn_load = 1'b1;
    repeat (7) tick();
    chk("lat_state_before", state, 2'b00);
    tick();
    chk("lat_A", A, 4'h9);
    chk("lat_state", state, 2'b01);
    repeat (12) tick();
    btn_load = 1'b0;
    repeat (10) tick();
    sw = 4'h6;
    press(1, 0, 10, 10);
    chk("pair_A", A, 4'h9);
    chk("pair_B", B, 4'h6);
    chk("pair_valid", valid, 1);
    chk("pair_state", state, 2'b10);

    // re-load from READY
    sw = 4'h2;
    press(1, 0, 10, 10);
    chk("reload_A", A, 4'h2);
    chk("reload_B", B, 4'h6);
    chk("reload_valid", valid, 0);
    chk("reload_state", state, 2'b01);

    // bounce rejection, then one capture after a stable hold
    sw = 4'hA;
    for (int k = 0; k < 5; k++) begin
      btn_load = 1'b1; repeat (3) tick();
      btn_load = 1'b0; repeat (3) tick();
    end
    chk("bounce_state", state, 2'b01);
    btn_load = 1'b1;
    repeat (10) tick();
    chk("bounce_hold_state", state, 2'b10);
    chk("bounce_hold_B", B, 4'hA);
    btn_load = 1'b0;
    repeat (10) tick();

    // clear and load together: clear wins
    sw = 4'h7;
    press(1, 1, 10, 10);
    chk("clr_A", A, 0);
    chk("clr_B", B, 0);
    chk("clr_valid", valid, 0);
    chk("clr_state", state, 2'b00);

    // long hold gives one capture; reset mid-press suppresses further ones
    sw = 4'h3; btn_load = 1'b1;
    repeat (100) tick();
    chk("hold_state", state, 2'b01);
    chk("hold_A", A, 4'h3);
    rst_pulse(4'h3);
    repeat (20) tick();
    chk("held_rst_state", state, 2'b00);
    chk("held_rst_A", A, 0);
    btn_load = 1'b0;
    repeat (10) tick();
    sw = 4'h5;
    press(1, 0, 10, 10);
    chk("repress_state", state, 2'b01);
    chk("repress_A", A, 4'h5);

    // randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_pulse(W'($urandom));
      end else begin
        btn_load  = ($urandom_range(0, 2) != 0);
        btn_clear = ($urandom_range(0, 7) == 0);
        sw        = W'($urandom);
        repeat ($urandom_range(1, 10)) tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream operand-entry stage for the 4-bit greater-than comparator.
- Captures operand A, then operand B, from board slide switches on debounced pushbutton presses.
- Holds both operands stable and flags a valid pair, so the comparator output can drive an LED.
- Raw switches and buttons are asynchronous to clk; this block synchronises and debounces them.

Parameters:
- WIDTH, 4: operand width in bits. Must be ≥1.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed to accept a button level change. Must be ≥1. The default is 10 ms at 100 MHz.

Ports:
- clk, input, 1: system clock. All state is on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- sw, input, WIDTH: raw slide switches, the operand source.
- btn_load, input, 1: raw pushbutton. Each accepted press loads the next operand.
- btn_clear, input, 1: raw pushbutton. An accepted press discards both operands.
- A, output, WIDTH: registered operand A, to the comparator A input.
- B, output, WIDTH: registered operand B, to the comparator B input.
- valid, output, 1: high while A and B form a complete pair.
- state, output, 2: FSM state for the status LEDs. 00 = WAIT_A, 01 = WAIT_B, 10 = READY.

Behaviour:
- Reset:
  - rst_n low asynchronously clears A, B, valid, all synchroniser flops, debounce counters, debounced levels and pulse registers.
  - The FSM goes to WAIT_A (state=00) immediately.
  - On release, the block starts on the first clock edge after rst_n is sampled high.
  - Reset in mid-press: the button is treated as released. A held button produces no pulse until it has been released and pressed again.
- Input conditioning:
  - sw, btn_load and btn_clear each pass through a 2-flop synchroniser.
  - The synchronised sw bus is the capture source. No debounce on sw.
- Debounce, one instance per button:
  - Counter of width clog2(DEBOUNCE_CYCLES+1).
  - If the synchronised level equals the debounced level, the counter is cleared to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Edge detect:
  - A registered one-cycle pulse (load_p / clear_p) fires on a debounced 0→1 transition only.
  - Holding a button gives exactly one pulse. Release gives none.
- Latency:
  - The raw button is first sampled high at edge 0.
  - The pulse is high during the cycle after edge DEBOUNCE_CYCLES+2.
  - The resulting A/B/valid/state update appears at edge DEBOUNCE_CYCLES+3.
- FSM:
  - WAIT_A + load_p → A ← sw_sync, go to WAIT_B. B and valid are unchanged (valid is 0).
  - WAIT_B + load_p → B ← sw_sync, valid ← 1, go to READY.
  - READY + load_p → A ← sw_sync, valid ← 0, go to WAIT_B. This starts a new pair. B keeps its old value until overwritten.
  - clear_p in any state → A ← 0, B ← 0, valid ← 0, go to WAIT_A.
  - clear_p and load_p in the same cycle: clear wins and the load is discarded.
  - Without a pulse, all outputs hold.
- Output timing:
  - A, B and valid change only on the same edge as the state transition.
  - They never glitch, because all are registered.
- The sw value captured is the synchronised value present in the pulse cycle. Switch moves after the capture do not affect A or B.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4):
- Reset:
  - Stimulus: assert rst_n=0 mid-cycle with sw=4'hF.
  - Required: A=0, B=0, valid=0, state=00 immediately, with no clock edge needed.
- Pair load:
  - Stimulus: sw=4'h9, press btn_load for 20 cycles, release; then sw=4'h6, press again.
  - Required: A=9 exactly 7 edges after the first press is sampled, state=01. Then B=6, valid=1, state=10.
- Bounce rejection:
  - Stimulus: toggle btn_load high/low with pulses of 3 cycles for 30 cycles, then hold high for 10 cycles.
  - Required: exactly one capture, occurring after the stable hold.
- Re-load from READY:
  - Stimulus: from A=9, B=6, READY, set sw=4'h2 and press load.
  - Required: A=2, B=6, valid=0, state=01.
- Clear priority:
  - Stimulus: release btn_load and btn_clear raw on the same edge after both are debounced low; press both together.
  - Required: A=0, B=0, valid=0, state=00, and no load capture.
- Held button and reset mid-press:
  - Stimulus: hold btn_load for 100 cycles.
  - Required: exactly one capture.
  - Stimulus: pulse rst_n low while btn_load is still held, then keep holding after release.
  - Required: no further captures until the button is released and pressed again.
